// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: bank of NUM_CSR control/status registers behind a
// valid/ready request port and a single-entry response register.
// Slot NUM_CSR-1 is a sticky LOCK register: bit i write-protects data slot i.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    request can be accepted this cycle
//   req_addr_i     target CSR index
//   req_op_i       00 NONE (read), 01 WRITE, 10 SET, 11 CLEAR
//   req_wdata_i    write data or bit mask
//   rsp_valid_o    response held
//   rsp_ready_i    response consumer ready
//   rsp_rdata_o    pre-update value of the addressed CSR
//   rsp_err_o      request rejected (out of range or locked)
//   csr_we_o       one-cycle pulse per committed write
//   csr_waddr_o    index of the committed write (valid with csr_we_o)
//   csr_q_o        all CSR values, slot i at [i*DATA_W +: DATA_W]
module csr_access_ctrl #(
  parameter int unsigned       NUM_CSR   = 8,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 3,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_W-1:0]         req_addr_i,
  input  logic [1:0]                req_op_i,
  input  logic [DATA_W-1:0]         req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      csr_we_o,
  output logic [ADDR_W-1:0]         csr_waddr_o,
  output logic [NUM_CSR*DATA_W-1:0] csr_q_o
);

  localparam int unsigned LOCK_IDX = NUM_CSR - 1;
  localparam int unsigned LOCK_W   = NUM_CSR - 1;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [DATA_W-1:0] data_q [LOCK_W];
  logic [LOCK_W-1:0] lock_q;
  logic [DATA_W-1:0] lock_word;

  int unsigned       addr_idx;
  logic              in_range;
  logic              is_lock;
  logic              slot_locked;
  logic [DATA_W-1:0] old_val;
  logic [DATA_W-1:0] wr_val;
  logic              err_nxt;
  logic              accept;
  logic              commit;

  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // LOCK reads back zero-extended; only the low LOCK_W bits exist.
  always_comb begin
    lock_word             = '0;
    lock_word[LOCK_W-1:0] = lock_q;
  end

  // Request decode. The slot search loop avoids indexing the array with an
  // address that may be out of range.
  always_comb begin
    addr_idx    = 32'(req_addr_i);
    in_range    = addr_idx < NUM_CSR;
    is_lock     = addr_idx == LOCK_IDX;
    old_val     = '0;
    slot_locked = 1'b0;
    for (int unsigned i = 0; i < LOCK_W; i++) begin
      if (addr_idx == i) begin
        old_val     = data_q[i];
        slot_locked = lock_q[i];
      end
    end
    if (is_lock) begin
      old_val = lock_word;
    end

    if (!in_range) begin
      err_nxt = 1'b1;
    end else if (req_op_i == OP_NONE) begin
      err_nxt = 1'b0;
    end else if (is_lock) begin
      err_nxt = req_op_i == OP_CLEAR;
    end else begin
      err_nxt = slot_locked;
    end

    case (req_op_i)
      OP_WRITE: wr_val = req_wdata_i;
      OP_SET:   wr_val = old_val | req_wdata_i;
      OP_CLEAR: wr_val = old_val & ~req_wdata_i;
      default:  wr_val = old_val;
    endcase

    commit = accept && !err_nxt && (req_op_i != OP_NONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LOCK_W; i++) begin
        data_q[i] <= RESET_VAL;
      end
      lock_q      <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      csr_we_o    <= 1'b0;
      csr_waddr_o <= '0;
    end else begin
      csr_we_o <= commit;

      // A pop and a new accept in the same cycle simply reload the register.
      if (accept) begin
        rsp_valid_o <= 1'b1;
        rsp_rdata_o <= in_range ? old_val : '0;
        rsp_err_o   <= err_nxt;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end

      if (commit) begin
        csr_waddr_o <= req_addr_i;
        if (is_lock) begin
          // CLEAR to LOCK never commits, so WRITE and SET both OR in.
          lock_q <= lock_q | req_wdata_i[LOCK_W-1:0];
        end else begin
          for (int unsigned i = 0; i < LOCK_W; i++) begin
            if (addr_idx == i) begin
              data_q[i] <= wr_val;
            end
          end
        end
      end
    end
  end

  for (genvar g = 0; g < LOCK_W; g++) begin : g_q
    assign csr_q_o[g*DATA_W +: DATA_W] = data_q[g];
  end
  assign csr_q_o[LOCK_IDX*DATA_W +: DATA_W] = lock_word;

endmodule

// File: doc/csr_access_ctrl.md
CSR_ACCESS_CTRL -- requirements
Module: csr_access_ctrl

Interface
REQ-001 The block SHALL take parameter NUM_CSR, default 8, as the number of CSR slots; the last slot (NUM_CSR-1) is the LOCK register.
REQ-002 The block SHALL take parameter DATA_W, default 32, as the CSR width; NUM_CSR-1 <= DATA_W is required.
REQ-003 The block SHALL take parameter ADDR_W, default 3, as the address width; 2**ADDR_W >= NUM_CSR is required.
REQ-004 The block SHALL take parameter RESET_VAL, default all zeros (DATA_W bits), as the reset value of data CSRs 0..NUM_CSR-2.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 req_valid_i  in  1  request present.
REQ-008 req_ready_o  out  1  request can be accepted this cycle.
REQ-009 req_addr_i  in  ADDR_W  target CSR index.
REQ-010 req_op_i  in  2  00 NONE (read), 01 WRITE, 10 SET, 11 CLEAR.
REQ-011 req_wdata_i  in  DATA_W  write data or bit mask.
REQ-012 rsp_valid_o  out  1  response held.
REQ-013 rsp_ready_i  in  1  response consumer ready.
REQ-014 rsp_rdata_o  out  DATA_W  pre-update value of the addressed CSR.
REQ-015 rsp_err_o  out  1  request rejected (out of range or locked).
REQ-016 csr_we_o  out  1  registered one-cycle pulse per committed write.
REQ-017 csr_waddr_o  out  ADDR_W  index of the committed write; valid while csr_we_o=1.
REQ-018 csr_q_o  out  NUM_CSR*DATA_W  all CSR values; slot i at bits [i*DATA_W +: DATA_W].

Function
REQ-019 Accept SHALL occur when req_valid_i && req_ready_o at a rising edge.
REQ-020 req_ready_o SHALL equal !rsp_valid_o || rsp_ready_i (single-entry response register, full throughput).
REQ-021 On accept, rsp_valid_o SHALL rise the next cycle and hold, with rdata/err stable, until rsp_valid_o && rsp_ready_i at an edge.
REQ-022 A simultaneous response pop and new accept SHALL reload the response register with no bubble.
REQ-023 Write value SHALL be: WRITE -> wdata; SET -> old | wdata; CLEAR -> old & ~wdata; NONE -> no write.
REQ-024 A committed write SHALL update the CSR at the accept edge, so it is visible on csr_q_o and to a back-to-back request in the next cycle.
REQ-025 csr_we_o SHALL be 1 for exactly the cycle after each committing accept and 0 otherwise; NONE and errored requests do not pulse.
REQ-026 addr >= NUM_CSR SHALL give err=1 and rdata=0, with no state change.
REQ-027 A non-NONE op to data CSR i while LOCK bit i = 1 SHALL give err=1 with rdata = current value and no change.
REQ-028 LOCK is sticky: WRITE and SET OR wdata[NUM_CSR-2:0] into LOCK; CLEAR gives err=1 with no change; upper LOCK bits read 0.
REQ-029 A NONE op SHALL never error on an in-range address, including locked CSRs.
REQ-030 A write to LOCK that changes no bits SHALL still commit (err=0, csr_we_o pulses).

Reset
REQ-031 While rst=1, outputs SHALL be: data CSRs = RESET_VAL, LOCK = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, csr_we_o = 0, csr_waddr_o = 0.
REQ-032 Reset SHALL take effect asynchronously; a held response or pending pulse is dropped, and no register is left without a reset value.
REQ-033 req_ready_o SHALL be 1 on the first edge after rst deasserts.

Verification
REQ-034 Reset, then WRITE addr 2 data 0xA5 -> next cycle rsp rdata=RESET_VAL err=0, csr_we_o=1 waddr=2; slot 2 = 0xA5.
REQ-035 SET 0x0F then CLEAR 0x03 on addr 1 back-to-back, rsp_ready_i=1 -> rdata 0x0 then 0x0F; final slot 1 = 0x0C; two we pulses.
REQ-036 SET LOCK 0x04, then WRITE addr 2 0xFF -> err=1, slot 2 unchanged, no pulse; then NONE addr 2 -> err=0; then CLEAR LOCK -> err=1, LOCK=0x04.
REQ-037 rsp_ready_i=0 for 3 cycles after accept -> req_ready_o=0 and rsp fields stable; release -> one pop, then new accept the same cycle.
REQ-038 NONE to addr 9 with NUM_CSR=8, ADDR_W=4 -> err=1, rdata=0, no pulse.
REQ-039 Assert rst while rsp_valid_o=1 and LOCK=0x7F -> same cycle rsp_valid_o=0, all CSRs RESET_VAL, LOCK=0.
